// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and sizing for the pipeline hazard controller.
package hazard_ctrl_pkg;

   localparam int unsigned REG_W            = 2;
   localparam int unsigned CNT_W            = 3;
   localparam int unsigned DRAIN_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_INJECT = 2'd2
   } state_e;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl_lu_detect.sv
// Load-use hazard detect: decode source matches a load's destination in execute.
module lu_detect
   import hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] id_ra_i,
   input  logic [REG_W-1:0] id_rb_i,
   input  logic             id_use_ra_i,
   input  logic             id_use_rb_i,
   input  logic [REG_W-1:0] ex_rd_i,
   input  logic             ex_rw_i,
   input  logic             ex_mr_i,
   output logic             lu_o
);

   logic hit_a;
   logic hit_b;

   assign hit_a = id_use_ra_i && (id_ra_i == ex_rd_i);
   assign hit_b = id_use_rb_i && (id_rb_i == ex_rd_i);
   assign lu_o  = ex_mr_i && ex_rw_i && (hit_a || hit_b);

endmodule : lu_detect

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/inject control: load-use bubbles, taken-branch flushes,
// memory-wait freezes and interrupt drain-then-inject sequencing.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_ra,
   input  logic [REG_W-1:0] id_rb,
   input  logic             id_use_ra,
   input  logic             id_use_rb,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_RW,
   input  logic             ex_MR,
   input  logic             br_taken,
   input  logic             mem_busy,
   input  logic             intr,
   output logic             pc_ld,
   output logic             f_d_ld,
   output logic             d_ex_ld,
   output logic             ex_m_ld,
   output logic             f_d_flush,
   output logic             d_ex_flush,
   output logic             intr_inject,
   output logic             intr_ack,
   output logic [1:0]       state
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             ack_q, ack_d;
   logic             lu;

   lu_detect u_lu_detect (
      .id_ra_i     (id_ra),
      .id_rb_i     (id_rb),
      .id_use_ra_i (id_use_ra),
      .id_use_rb_i (id_use_rb),
      .ex_rd_i     (ex_rd),
      .ex_rw_i     (ex_RW),
      .ex_mr_i     (ex_MR),
      .lu_o        (lu)
   );

   // Next-state and per-cycle latch controls, priority mem_busy > branch > load-use > FSM.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q | intr;
      ack_d       = 1'b0;
      pc_ld       = 1'b0;
      f_d_ld      = 1'b0;
      d_ex_ld     = 1'b0;
      ex_m_ld     = 1'b0;
      f_d_flush   = 1'b0;
      d_ex_flush  = 1'b0;
      intr_inject = 1'b0;

      if (mem_busy) begin
         // whole pipeline frozen; only the pending request is captured
      end else if (br_taken) begin
         pc_ld      = 1'b1;
         f_d_ld     = 1'b1;
         d_ex_ld    = 1'b1;
         ex_m_ld    = 1'b1;
         f_d_flush  = 1'b1;
         d_ex_flush = 1'b1;
         if (state_q == ST_DRAIN) begin
            if (cnt_q <= CNT_W'(1)) state_d = ST_INJECT;
            else                    cnt_d   = cnt_q - CNT_W'(1);
         end else if (state_q == ST_INJECT) begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYCLES);
         end
      end else if (lu) begin
         d_ex_ld    = 1'b1;
         ex_m_ld    = 1'b1;
         d_ex_flush = 1'b1;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               pc_ld   = 1'b1;
               f_d_ld  = 1'b1;
               d_ex_ld = 1'b1;
               ex_m_ld = 1'b1;
               if (intr || pend_q) begin
                  state_d = ST_DRAIN;
                  cnt_d   = CNT_W'(DRAIN_CYCLES);
                  pend_d  = 1'b0;
               end
            end
            ST_DRAIN: begin
               f_d_ld    = 1'b1;
               d_ex_ld   = 1'b1;
               ex_m_ld   = 1'b1;
               f_d_flush = 1'b1;
               if (cnt_q <= CNT_W'(1)) state_d = ST_INJECT;
               else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_INJECT: begin
               f_d_ld      = 1'b1;
               d_ex_ld     = 1'b1;
               ex_m_ld     = 1'b1;
               intr_inject = 1'b1;
               state_d     = ST_RUN;
               ack_d       = 1'b1;
            end
            default: state_d = ST_RUN;
         endcase
      end

      // pipeline held cleared while reset is asserted
      if (reset) begin
         pc_ld       = 1'b0;
         f_d_ld      = 1'b0;
         d_ex_ld     = 1'b0;
         ex_m_ld     = 1'b0;
         f_d_flush   = 1'b1;
         d_ex_flush  = 1'b1;
         intr_inject = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ack_q   <= ack_d;
      end
   end

   assign intr_ack = ack_q;
   assign state    = state_q;

endmodule : hazard_ctrl
